// File: rtl/ipsl_ddrphy_dll_update_ctrl.sv
// DLL code-update sequencer: freeze, strobe update, hold, then four-phase ack to the
// granted requester (reset controller has priority over training).
module ipsl_ddrphy_dll_update_ctrl #(
    parameter int unsigned FREEZE_SETUP = 2,
    parameter int unsigned UPDATE_PULSE = 4,
    parameter int unsigned FREEZE_HOLD  = 4
) (
    input  logic       clk,
    input  logic       srb_rst_dll,
    input  logic       dll_lock,
    input  logic       dll_update_req_rst_ctrl,
    output logic       dll_update_ack_rst_ctrl,
    input  logic       dll_update_req_training,
    output logic       dll_update_ack_training,
    output logic       dll_freeze,
    output logic       dll_update_n,
    output logic       update_busy,
    output logic       lock_lost_err,
    output logic [7:0] update_cnt
);

    localparam logic [3:0] FsLoad = 4'(FREEZE_SETUP - 1);
    localparam logic [3:0] UpLoad = 4'(UPDATE_PULSE - 1);
    localparam logic [3:0] FhLoad = 4'(FREEZE_HOLD - 1);

    typedef enum logic [2:0] {StIdle, StFreeze, StUpdate, StHold, StAck} state_e;

    state_e     state_q, state_d;
    logic [3:0] tmr_q, tmr_d;
    logic       owner_q, owner_d;  // 0: reset controller, 1: training
    logic       lock_meta_q, dll_lock_s;
    logic       freeze_q, upd_n_q, ack_rst_q, ack_trn_q, err_q, err_d;
    logic [7:0] cnt_q;
    logic       done;
    logic       seq_active;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        owner_d = owner_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dll_lock_s && (dll_update_req_rst_ctrl || dll_update_req_training)) begin
                    owner_d = ~dll_update_req_rst_ctrl;
                    tmr_d   = FsLoad;
                    state_d = StFreeze;
                end
            end
            StFreeze: begin
                if (tmr_q == 4'd0) begin
                    tmr_d   = UpLoad;
                    state_d = StUpdate;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            StUpdate: begin
                if (tmr_q == 4'd0) begin
                    tmr_d   = FhLoad;
                    state_d = StHold;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            StHold: begin
                if (tmr_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            StAck: begin
                if (!(owner_q ? dll_update_req_training : dll_update_req_rst_ctrl)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign seq_active = (state_q == StFreeze) || (state_q == StUpdate) || (state_q == StHold);
    assign err_d      = err_q | (seq_active & ~dll_lock_s);

    always_ff @(posedge clk or posedge srb_rst_dll) begin
        if (srb_rst_dll) begin
            state_q     <= StIdle;
            tmr_q       <= 4'd0;
            owner_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            dll_lock_s  <= 1'b0;
            freeze_q    <= 1'b0;
            upd_n_q     <= 1'b1;
            ack_rst_q   <= 1'b0;
            ack_trn_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            owner_q     <= owner_d;
            lock_meta_q <= dll_lock;
            dll_lock_s  <= lock_meta_q;
            // Outputs decoded from the next state so they move on the transition edge.
            freeze_q    <= (state_d == StFreeze) || (state_d == StUpdate) || (state_d == StHold);
            upd_n_q     <= (state_d != StUpdate);
            ack_rst_q   <= (state_d == StAck) && !owner_d;
            ack_trn_q   <= (state_d == StAck) && owner_d;
            err_q       <= err_d;
            if (done && (cnt_q != 8'hff)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign dll_freeze              = freeze_q;
    assign dll_update_n            = upd_n_q;
    assign dll_update_ack_rst_ctrl = ack_rst_q;
    assign dll_update_ack_training = ack_trn_q;
    assign update_busy             = (state_q != StIdle);
    assign lock_lost_err           = err_q;
    assign update_cnt              = cnt_q;

endmodule

// File: tb/tb_ipsl_ddrphy_dll_update_ctrl.sv
// Bench for ipsl_ddrphy_dll_update_ctrl: per-cycle expected outputs are queued from the
// documented sequence timing and compared one per clock edge.
module tb_ipsl_ddrphy_dll_update_ctrl;

    localparam int FS = 2;
    localparam int UP = 4;
    localparam int FH = 4;

    logic       clk = 1'b0;
    logic       srb_rst_dll;
    logic       dll_lock;
    logic       req_r;
    logic       req_t;
    logic       ack_r;
    logic       ack_t;
    logic       dll_freeze;
    logic       dll_update_n;
    logic       update_busy;
    logic       lock_lost_err;
    logic [7:0] update_cnt;

    ipsl_ddrphy_dll_update_ctrl #(
        .FREEZE_SETUP(FS),
        .UPDATE_PULSE(UP),
        .FREEZE_HOLD (FH)
    ) dut (
        .clk                    (clk),
        .srb_rst_dll            (srb_rst_dll),
        .dll_lock               (dll_lock),
        .dll_update_req_rst_ctrl(req_r),
        .dll_update_ack_rst_ctrl(ack_r),
        .dll_update_req_training(req_t),
        .dll_update_ack_training(ack_t),
        .dll_freeze             (dll_freeze),
        .dll_update_n           (dll_update_n),
        .update_busy            (update_busy),
        .lock_lost_err          (lock_lost_err),
        .update_cnt             (update_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       freeze;
        logic       upd_n;
        logic       ack_r;
        logic       ack_t;
        logic       busy;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        bit r;
        bit t;
        int hold_r;
        int hold_t;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[5];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    int   step_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        obs_t e;
        obs_t a;
        @(posedge clk);
        #1;
        step_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dll_freeze, dll_update_n, ack_r, ack_t, update_busy, update_cnt};
            check($sformatf("cycle%0d {freeze,upd_n,ack_r,ack_t,busy,cnt}", step_no),
                  32'(a), 32'(e));
        end
    endtask

    task automatic push_n(input logic f, input logic u, input logic ar, input logic at,
                          input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({f, u, ar, at, b, 8'(exp_cnt)});
    endtask

    // One full sequence: FS freeze-only, UP strobe, FH hold, hold ack cycles, then release.
    task automatic push_seq(input bit owner, input int hold);
        push_n(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FS);
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, UP);
        push_n(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FH);
        push_n(1'b0, 1'b1, !owner, owner, 1'b1, hold);
        if (exp_cnt < 255) exp_cnt++;
        push_n(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    endtask

    // Request must already be high so that the next edge accepts it.
    task automatic serve(input bit owner, input int hold);
        push_seq(owner, hold);
        repeat (FS + UP + FH + hold) step();
        if (owner) req_t = 1'b0;
        else req_r = 1'b0;
        step();
    endtask

    task automatic idle(input int n);
        push_n(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, n);
        repeat (n) step();
    endtask

    initial begin
        vecs[0] = '{r: 1'b1, t: 1'b0, hold_r: 4, hold_t: 0};
        vecs[1] = '{r: 1'b0, t: 1'b1, hold_r: 0, hold_t: 1};
        vecs[2] = '{r: 1'b1, t: 1'b1, hold_r: 4, hold_t: 2};
        vecs[3] = '{r: 1'b0, t: 1'b1, hold_r: 0, hold_t: 3};
        vecs[4] = '{r: 1'b1, t: 1'b0, hold_r: 1, hold_t: 0};

        srb_rst_dll = 1'b1;
        dll_lock    = 1'b1;
        req_r       = 1'b1;
        req_t       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'({dll_freeze, dll_update_n, ack_r, ack_t, update_busy,
                                    update_cnt}), 32'({5'b01000, 8'd0}));
        check("reset lock_lost_err", 32'(lock_lost_err), 32'd0);

        // Release with lock high: two sync edges, then the rst-ctrl request is taken.
        req_t       = 1'b0;
        srb_rst_dll = 1'b0;
        idle(2);
        serve(1'b0, 4);
        idle(2);

        foreach (vecs[i]) begin
            req_r = vecs[i].r;
            req_t = vecs[i].t;
            if (vecs[i].r) serve(1'b0, vecs[i].hold_r);
            if (vecs[i].t) serve(1'b1, vecs[i].hold_t);
            idle(2);
        end

        // No lock: pending request waits until the synchronised lock is seen.
        dll_lock = 1'b0;
        idle(2);
        req_t = 1'b1;
        idle(5);
        dll_lock = 1'b1;
        idle(2);
        serve(1'b1, 2);
        idle(1);
        check("no lock_lost_err yet", 32'(lock_lost_err), 32'd0);

        // Lock drops while the strobe is active; the sequence still runs to completion.
        req_r = 1'b1;
        push_seq(1'b0, 4);
        repeat (FS + 1) step();
        dll_lock = 1'b0;
        repeat (2) step();
        dll_lock = 1'b1;
        repeat (UP + FH + 4 - 3) step();
        check("lock_lost_err set", 32'(lock_lost_err), 32'd1);
        req_r = 1'b0;
        step();
        idle(3);
        check("lock_lost_err sticky", 32'(lock_lost_err), 32'd1);

        // Reset in the middle of the update strobe.
        req_r = 1'b1;
        push_n(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FS);
        push_n(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        repeat (FS + 1) step();
        #2;
        srb_rst_dll = 1'b1;
        req_r       = 1'b0;
        #1;
        check("async reset freeze/upd_n", 32'({dll_freeze, dll_update_n}), 32'(2'b01));
        check("async reset cnt/busy/acks", 32'({update_cnt, update_busy, ack_r, ack_t}),
              32'd0);
        check("async reset clears err", 32'(lock_lost_err), 32'd0);
        #1;
        srb_rst_dll = 1'b0;
        exp_cnt     = 0;
        idle(6);
        req_t = 1'b1;
        serve(1'b1, 1);
        idle(1);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
